// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA timing generator: standard mode sets,
// default counter width, delay-pipeline bounds and the generator state type.
package vga_timing_pkg;

    // 800x600 @ 60 Hz (40 MHz pixel clock)
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs
    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    localparam int DEFAULT_CW    = 12;
    localparam int PIPE_DLY_MIN  = 1;
    localparam int PIPE_DLY_MAX  = 8;

    typedef enum logic {ST_IDLE, ST_RUN} gen_state_t;

    // Bits needed to hold the values 0..total-1.
    function automatic int count_bits(input int total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset value; used to align
// the sync/blank outputs a constant number of cycles behind the counters.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_p[i] <= RST_VAL;
        end else begin
            stage_p[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
        end
    end

    assign q = stage_p[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters with frame-aligned start/stop,
// sync/active-video outputs delayed PIPE_DLY cycles, and a frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1,
    parameter int CW       = DEFAULT_CW,
    parameter int PIPE_DLY = 2
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic          running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (CW < count_bits(H_TOTAL) || CW < count_bits(V_TOTAL)) begin : g_cw_check
        $error("vga_timing_gen: CW=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
               CW, H_TOTAL - 1, V_TOTAL - 1);
    end
    if (PIPE_DLY < PIPE_DLY_MIN || PIPE_DLY > PIPE_DLY_MAX) begin : g_dly_check
        $error("vga_timing_gen: PIPE_DLY=%0d out of range", PIPE_DLY);
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (H_POL != 0);
    localparam logic          VS_ON    = (V_POL != 0);

    gen_state_t state;

    // Stops are only taken on the last pixel of a frame, so a late en
    // re-assertion simply cancels the pending stop.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hcount    <= '0;
            vcount    <= '0;
            frame_cnt <= '0;
        end else begin
            if (frame_start) frame_cnt <= frame_cnt + 8'd1;
            case (state)
                ST_IDLE: begin
                    hcount <= '0;
                    vcount <= '0;
                    if (en) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (hcount == H_LAST) begin
                        hcount <= '0;
                        if (vcount == V_LAST) begin
                            vcount <= '0;
                            if (!en) state <= ST_IDLE;
                        end else begin
                            vcount <= vcount + CW'(1);
                        end
                    end else begin
                        hcount <= hcount + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign running     = (state == ST_RUN);
    assign line_start  = running && (hcount == '0);
    assign frame_start = line_start && (vcount == '0);

    logic hs_act, vs_act, de_raw;
    logic [2:0] raw_p0, dly_pn;

    assign hs_act = running && (hcount >= HS_START) && (hcount < HS_END);
    assign vs_act = running && (vcount >= VS_START) && (vcount < VS_END);
    assign de_raw = running && (hcount < H_ACT_C) && (vcount < V_ACT_C);
    assign raw_p0 = {hs_act ? HS_ON : ~HS_ON, vs_act ? VS_ON : ~VS_ON, de_raw};

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DLY),
        .RST_VAL ({~HS_ON, ~VS_ON, 1'b0})
    ) u_dly (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .d         (raw_p0),
        .q         (dly_pn)
    );

    assign hs    = dly_pn[2];
    assign vs    = dly_pn[1];
    assign de    = dly_pn[0];
    assign blank = ~dly_pn[0];

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameter H_FP, 40, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 128, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 88, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 600, visible lines per frame.
REQ-006 Parameter V_FP, 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 4, vertical sync width in lines.
REQ-008 Parameter V_BP, 23, vertical back porch in lines.
REQ-009 Parameter H_POL, 1, asserted level of hs.
REQ-010 Parameter V_POL, 1, asserted level of vs.
REQ-011 Parameter CW, 12, hcount/vcount width.
REQ-012 Parameter PIPE_DLY, 2, cycles from a counter value to its sync/blank/de outputs; legal range 1..8.
REQ-013 pixel_clk  in  1  pixel clock; all logic on its rising edge.
REQ-014 rst  in  1  reset, synchronous, active-high.
REQ-015 en  in  1  run request; starts and stops only on frame boundaries.
REQ-016 hcount, vcount  out  CW each  current pixel coordinate.
REQ-017 hs, vs  out  1 each  sync outputs, delayed PIPE_DLY.
REQ-018 de, blank  out  1 each  active-video flag and its inverse, delayed PIPE_DLY.
REQ-019 line_start, frame_start  out  1 each  single-cycle pulses, counter-aligned (not delayed).
REQ-020 frame_cnt  out  8  completed-frame-start count.
REQ-021 running  out  1  timing generator active.

Function
REQ-022 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; hcount covers exactly 0..H_TOTAL-1, vcount 0..V_TOTAL-1.
REQ-023 While running, hcount increments each cycle and wraps H_TOTAL-1 -> 0; vcount increments only on that wrap cycle and wraps V_TOTAL-1 -> 0.
REQ-024 Idle (running=0): hcount=vcount=0 held; if en=1, running becomes 1 next cycle and counting starts from (0,0) on that cycle.
REQ-025 Running with en=0: frame continues to (H_TOTAL-1, V_TOTAL-1); next cycle running=0, counters (0,0); en re-asserted before that point cancels the stop.
REQ-026 Undelayed hs active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC and running; output level H_POL, else ~H_POL.
REQ-027 Undelayed vs active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC and running; level V_POL, else ~V_POL.
REQ-028 Undelayed de = running and hcount<H_ACTIVE and vcount<V_ACTIVE; blank = ~de.
REQ-029 hs/vs/de/blank outputs equal undelayed values exactly PIPE_DLY cycles earlier; after running drops, tail of pipeline drains normally.
REQ-030 line_start=1 on any cycle with running and hcount=0; frame_start=1 when additionally vcount=0.
REQ-031 frame_cnt increments on each frame_start cycle (visible next cycle), wraps 255 -> 0.
REQ-032 CW smaller than needed for H_TOTAL-1 or V_TOTAL-1 shall be an elaboration error.

Reset
REQ-033 rst=1: next cycle hcount=vcount=0, running=0, frame_cnt=0, line_start=frame_start=0, de=0, blank=1, hs=~H_POL, vs=~V_POL, delay pipeline filled with inactive values.
REQ-034 rst mid-frame overrides en and all pending stops; no stale pipeline value appears after release.

Structure
REQ-035 Package vga_timing_pkg holds timing constant sets (800x600@60, 640x480@60), default CW, PIPE_DLY bounds.
REQ-036 Sub-module vga_delay_line: parametrised width/depth shift register with synchronous reset value, used for the PIPE_DLY alignment.

Verification
REQ-037 Defaults, en=1 after reset: hcount period 1056, vcount period 628; hs high 128 cycles, first at hcount 842 (840+2).
REQ-038 en dropped at vcount 300: counting continues to (1055,627), running=0 next cycle, counters hold 0, de never reasserts.
REQ-039 640x480 set (48/96/16... 16/96/48, V 10/2/33), H_POL=V_POL=0: H_TOTAL 800, hs low 96 cycles from hcount 656, vs low 2 lines from vcount 490.
REQ-040 rst at (500,200): next cycle counters 0, running 0, blank 1, hs/vs inactive for all following PIPE_DLY cycles.
REQ-041 Tiny params (active 4x2, porches/syncs 1): 257 frames -> frame_cnt 255 -> 0, frame_start exactly one cycle per frame.
REQ-042 PIPE_DLY=1 and 3: de rises exactly 1 and 3 cycles after frame_start respectively.
